// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port arbiter for the single data-memory port, one
//            transaction at a time, with registered per-port responses.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int FIXED_PRIO = 1,
    parameter int TIMEOUT    = 64,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_err,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic [1:0]    mem_status,
    output logic          busy
);

    localparam int              c_CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CW-1:0] c_TMO_LAST = c_CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [1:0]      c_ST_DONE  = 2'b10;
    localparam logic [1:0]      c_ST_ERR   = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_owner;
    logic            r_last_owner;
    logic [c_CW-1:0] r_cnt;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_p0_rvalid, r_p1_rvalid;
    logic            r_p0_err, r_p1_err;
    logic [DW-1:0]   r_p0_rdata, r_p1_rdata;
    logic            w_pick1;
    logic            w_start;
    logic            w_done;
    logic            w_fail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grants are gated by rst so nothing is offered while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        p0_gnt      = 1'b0;
        p1_gnt      = 1'b0;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_fail      = 1'b0;
        w_pick1     = p1_req && (!p0_req || ((FIXED_PRIO == 0) && !r_last_owner));
        case (r_state)
            S_IDLE: begin
                if (!rst && (p0_req || p1_req)) begin
                    w_start     = 1'b1;
                    p0_gnt      = !w_pick1;
                    p1_gnt      = w_pick1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_done = (mem_status == c_ST_DONE);
                w_fail = (mem_status == c_ST_ERR) ||
                         ((TIMEOUT != 0) && (r_cnt == c_TMO_LAST) && !w_done);
                if (w_done || w_fail) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_cnt        <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_p0_rvalid  <= 1'b0;
            r_p1_rvalid  <= 1'b0;
            r_p0_err     <= 1'b0;
            r_p1_err     <= 1'b0;
            r_p0_rdata   <= '0;
            r_p1_rdata   <= '0;
        end else begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_err    <= 1'b0;
            r_p1_err    <= 1'b0;
            if (w_start) begin
                r_mem_we     <= w_pick1 ? p1_we    : p0_we;
                r_mem_addr   <= w_pick1 ? p1_addr  : p0_addr;
                r_mem_wdata  <= w_pick1 ? p1_wdata : p0_wdata;
                r_owner      <= w_pick1;
                r_last_owner <= w_pick1;
                r_cnt        <= '0;
            end else if ((r_state == S_ACCESS) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + c_CW'(1);
            end
            // Read data is only returned for successful reads; rdata holds afterwards.
            if (w_done || w_fail) begin
                if (r_owner) begin
                    r_p1_rvalid <= 1'b1;
                    r_p1_err    <= w_fail;
                    r_p1_rdata  <= (w_done && !r_mem_we) ? mem_rdata : '0;
                end else begin
                    r_p0_rvalid <= 1'b1;
                    r_p0_err    <= w_fail;
                    r_p0_rdata  <= (w_done && !r_mem_we) ? mem_rdata : '0;
                end
            end
        end
    end

    assign mem_en    = (r_state == S_ACCESS);
    assign busy      = (r_state == S_ACCESS);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign p0_rvalid = r_p0_rvalid;
    assign p1_rvalid = r_p1_rvalid;
    assign p0_err    = r_p0_err;
    assign p1_err    = r_p1_err;
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed bench; A is round-robin with TIMEOUT=8, B is fixed
//            priority with timeout disabled. Both share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_BUSY = 2'b01;
    localparam logic [1:0] c_DONE = 2'b10;
    localparam logic [1:0] c_ERR  = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic [31:0] mem_rdata = '0;
    logic [1:0]  mem_status = c_IDLE;

    logic        a_p0_gnt, a_p0_rvalid, a_p0_err, a_p1_gnt, a_p1_rvalid, a_p1_err;
    logic [31:0] a_p0_rdata, a_p1_rdata, a_mem_addr, a_mem_wdata;
    logic        a_mem_en, a_mem_we, a_busy;
    logic        b_p0_gnt, b_p0_rvalid, b_p0_err, b_p1_gnt, b_p1_rvalid, b_p1_err;
    logic [31:0] b_p0_rdata, b_p1_rdata, b_mem_addr, b_mem_wdata;
    logic        b_mem_en, b_mem_we, b_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.FIXED_PRIO(0), .TIMEOUT(8), .AW(32), .DW(32)) u_dut_a (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(a_p0_gnt), .p0_rvalid(a_p0_rvalid), .p0_rdata(a_p0_rdata), .p0_err(a_p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(a_p1_gnt), .p1_rvalid(a_p1_rvalid), .p1_rdata(a_p1_rdata), .p1_err(a_p1_err),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(mem_rdata), .mem_status(mem_status), .busy(a_busy)
    );

    dmem_arbiter #(.FIXED_PRIO(1), .TIMEOUT(0), .AW(32), .DW(32)) u_dut_b (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata), .p0_err(b_p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata), .p1_err(b_p1_err),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(mem_rdata), .mem_status(mem_status), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then let combinational outputs settle.
    task automatic step(input logic r0, input logic r1, input logic [1:0] st, input logic [31:0] rd);
        @(negedge clk);
        p0_req     = r0;
        p1_req     = r1;
        mem_status = st;
        mem_rdata  = rd;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int en_cnt;
        int rv_cnt;
        logic ga, pa;

        // Reset state
        @(negedge clk); #1;
        check("rst_outputs", {a_p0_gnt, a_p1_gnt, a_p0_rvalid, a_p1_rvalid, a_p0_err, a_p1_err,
                              a_mem_en, a_mem_we, a_busy}, 0);
        check("rst_mem_addr", a_mem_addr, 0);
        check("rst_rdata", a_p0_rdata | a_p1_rdata | a_mem_wdata, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Port 0 read, three BUSY then DONE
        p0_we = 1'b0; p0_addr = 32'h10;
        step(1, 0, c_IDLE, 0);
        check("t1_gnt", {a_p0_gnt, a_p1_gnt}, 2'b10);
        check("t1_mem_en_idle", a_mem_en, 0);
        en_cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, (i < 4) ? c_BUSY : ((i == 4) ? c_DONE : c_IDLE), (i == 4) ? 32'hDEADBEEF : 32'h0);
            if (a_mem_en) en_cnt++;
            if (i == 1) check("t1_mem_addr", a_mem_addr, 32'h10);
        end
        check("t1_mem_en_cycles", en_cnt, 4);
        check("t1_p0_rvalid", a_p0_rvalid, 1);
        check("t1_p0_rdata", a_p0_rdata, 32'hDEADBEEF);
        check("t1_p0_err", a_p0_err, 0);
        check("t1_p1_rvalid", a_p1_rvalid, 0);
        step(0, 0, c_IDLE, 0);
        check("t1_rvalid_pulse", a_p0_rvalid, 0);
        check("t1_rdata_hold", a_p0_rdata, 32'hDEADBEEF);

        // Both ports requesting continuously, DONE every access
        p0_addr = 32'h100; p1_addr = 32'h200; p1_we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1, 1, c_DONE, 32'h1000 + k);
            ga = (((k / 2) % 2) == 0);
            if ((k % 2) == 0) begin
                check("t2_a_gnt", {a_p1_gnt, a_p0_gnt}, {ga, !ga});
                check("t2_b_gnt", {b_p1_gnt, b_p0_gnt}, 2'b01);
                if (k > 0) begin
                    pa = ((((k - 2) / 2) % 2) == 0);
                    check("t2_a_rvalid", {a_p1_rvalid, a_p0_rvalid}, {pa, !pa});
                    check("t2_a_rdata", pa ? a_p1_rdata : a_p0_rdata, 32'h1000 + k - 1);
                    check("t2_b_rvalid", {b_p1_rvalid, b_p0_rvalid}, 2'b01);
                end
            end else begin
                check("t2_a_no_gnt", {a_p1_gnt, a_p0_gnt, b_p1_gnt, b_p0_gnt}, 0);
                check("t2_a_no_rvalid", {a_p1_rvalid, a_p0_rvalid}, 0);
                check("t2_a_mem_addr", a_mem_addr, ga ? 32'h200 : 32'h100);
            end
        end
        step(0, 1, c_IDLE, 0);
        check("t3_b_p1_gnt", {b_p1_gnt, b_p0_gnt}, 2'b10);
        check("t3_a_p1_gnt", {a_p1_gnt, a_p0_gnt}, 2'b10);
        step(0, 0, c_DONE, 32'h55);
        step(0, 0, c_IDLE, 0);
        check("t3_b_p1_rvalid", {b_p1_rvalid, b_p0_rvalid}, 2'b10);
        check("t3_b_p1_rdata", b_p1_rdata, 32'h55);

        // Port 1 write answered with ERROR
        p1_we = 1'b1; p1_addr = 32'h40; p1_wdata = 32'h12345678;
        step(0, 1, c_IDLE, 0);
        check("t4_gnt", {a_p1_gnt, b_p1_gnt}, 2'b11);
        step(0, 0, c_ERR, 32'hFFFF_FFFF);
        check("t4_mem_ctrl", {a_mem_en, a_mem_we}, 2'b11);
        check("t4_mem_addr", a_mem_addr, 32'h40);
        check("t4_mem_wdata", a_mem_wdata, 32'h12345678);
        step(0, 0, c_IDLE, 0);
        check("t4_p1_resp", {a_p1_rvalid, a_p1_err, a_p0_rvalid}, 3'b110);
        check("t4_p1_rdata", a_p1_rdata, 0);
        check("t4_b_p1_err", {b_p1_rvalid, b_p1_err}, 2'b11);

        // Memory stuck BUSY: A times out after 8 cycles, B waits forever
        p0_we = 1'b0; p1_we = 1'b0; p0_addr = 32'h80;
        step(1, 0, c_IDLE, 0);
        check("t5_gnt", {a_p0_gnt, b_p0_gnt}, 2'b11);
        rv_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, c_BUSY, 0);
            if (a_p0_rvalid || a_p1_rvalid) rv_cnt++;
        end
        check("t5_no_early_rvalid", rv_cnt, 0);
        step(0, 1, c_BUSY, 0);
        check("t5_a_timeout", {a_p0_rvalid, a_p0_err, a_busy}, 3'b110);
        check("t5_a_rdata", a_p0_rdata, 0);
        check("t5_b_still_busy", {b_busy, b_p0_rvalid}, 2'b10);
        check("t5_a_new_gnt", {a_p1_gnt, b_p1_gnt}, 2'b10);
        step(0, 0, c_DONE, 32'hCAFE0001);
        step(0, 0, c_IDLE, 0);
        check("t5_a_p1_resp", {a_p1_rvalid, a_p1_err}, 2'b10);
        check("t5_a_p1_rdata", a_p1_rdata, 32'hCAFE0001);
        check("t5_b_p0_resp", {b_p0_rvalid, b_p0_err}, 2'b10);

        // Reset during the second ACCESS cycle
        step(1, 0, c_IDLE, 0);
        check("t6_gnt", a_p0_gnt, 1);
        step(0, 0, c_BUSY, 0);
        step(1, 1, c_BUSY, 0);
        check("t6_no_gnt_access", {a_p0_gnt, a_p1_gnt, a_busy}, 3'b001);
        rst = 1'b1;
        #1;
        check("t6_rst_async", {a_mem_en, a_busy, a_p0_gnt, a_p1_gnt, a_p0_rvalid, a_p1_rvalid,
                               b_mem_en, b_busy, b_p0_gnt, b_p1_gnt}, 0);
        check("t6_rst_mem_addr", a_mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        mem_status = c_IDLE;
        #1;
        check("t6_tie_p0", {a_p1_gnt, a_p0_gnt}, 2'b01);
        check("t6_no_stale_rvalid", {a_p0_rvalid, a_p1_rvalid}, 0);
        step(0, 0, c_DONE, 32'h77);
        step(0, 0, c_IDLE, 0);
        check("t6_new_rvalid", {a_p0_rvalid, a_p1_rvalid}, 2'b10);
        check("t6_new_rdata", a_p0_rdata, 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
